addr_inc_sequencer: RTL and testbench
=====================================

Name: addr_inc_sequencer

Overview:
- Parametrised successor to the single incrementer register on the address bus.
- Holds NUM_REGS address-class registers (PC, XY, M, J, ...) plus an internal INC latch.
- Runs the relay computer's increment sequence autonomously, with relay-style dwell timing:
  - drive source register onto the address bus, latch source+STEP into INC;
  - release the bus;
  - drive INC onto the bus and load the destination register.
- Also provides manual load/select of each register from the control bus when idle.

Parameters:
- N, 16, register and address-bus width in bits.
- NUM_REGS, 4, number of address-class registers; register index width IW = $clog2(NUM_REGS), minimum 1.
- STEP, 1, increment amount added per sequence, interpreted as unsigned modulo 2^N.
- DWELL, 2, cycles each bus phase (SRC, DST) is held; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request an increment sequence; sampled only in IDLE.
- src_idx  in  IW  source register index; captured with start.
- dst_idx  in  IW  destination register index; captured with start; may equal src_idx.
- ld_vec  in  NUM_REGS  manual load strobes; register i loads addr_in at clk edge (IDLE only).
- sel_vec  in  NUM_REGS  manual select strobes; register i drives addr_out (IDLE only).
- addr_in  in  N  address bus value seen by the block.
- addr_out  out  N  value this block drives onto the address bus.
- addr_oe  out  1  address-bus drive enable.
- inc_value  out  N  current INC latch content.
- carry  out  1  carry out of the last increment.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at sequence end.
- contention  out  1  more than one sel_vec bit asserted while IDLE.
- led_ld  out  NUM_REGS+1  load indicators for the panel; MSB = INC.
- led_sel  out  NUM_REGS+1  select indicators for the panel; MSB = INC.

Behaviour:
- Reset (asynchronous, active-high): all registers, INC, carry, captured indices and dwell counter = 0; state IDLE. All outputs are 0, including addr_oe, busy, done and contention.
- States: IDLE, SRC, GAP, DST, DONE.
- IDLE:
  - start=1 at an edge captures src_idx/dst_idx; next state SRC; dwell counter cleared.
  - Otherwise, manual mode:
    - For each i with ld_vec[i]=1, reg[i] <= addr_in.
    - addr_out = OR of reg[i] over all set sel_vec bits; addr_oe = |sel_vec.
    - contention = popcount(sel_vec) > 1.
  - If start and ld_vec arrive in the same cycle, start wins and ld_vec is ignored.
- SRC, for DWELL cycles:
  - addr_oe=1, addr_out=reg[src].
  - led_sel[src]=1, led_ld[INC]=1.
  - On the final SRC edge: {carry, INC} <= reg[src] + STEP, (N+1)-bit sum.
- GAP, 1 cycle: addr_oe=0 and addr_out=0 (break-before-make).
- DST, for DWELL cycles:
  - addr_oe=1, addr_out=INC.
  - led_sel[INC]=1, led_ld[dst]=1.
  - On the final DST edge: reg[dst] <= INC.
- DONE, 1 cycle: done=1, busy=1, bus released; next state IDLE.
- Sequence latency: start accepted at edge k gives done high during cycle k+2·DWELL+2.
- While busy: start, ld_vec and sel_vec are ignored; contention = 0.
- Wrap-around: reg[src] + STEP ≥ 2^N wraps modulo 2^N and sets carry. carry holds its value until the next SRC latch.
- src_idx ≥ NUM_REGS (only possible when NUM_REGS is not a power of two): the sequence runs, but the read yields 0 and the write is dropped.
- Reset asserted mid-sequence: immediate return to IDLE with everything zeroed; no partial destination write.

Optional Feature:
- Macro ADDR_INC_DECREMENT_EN.
- When defined:
  - Adds input port dec (1 bit), captured with start.
  - If dec=1, INC latch <= reg[src] − STEP modulo 2^N, and carry is set on borrow (reg[src] < STEP).
- When undefined: the port is absent and the block always increments.

Decomposition:
- Package addr_inc_pkg:
  - state enum type;
  - localparam for the INC LED bit position (NUM_REGS);
  - function computing the (N+1)-bit add/sub result.
- One sub-module, addr_reg_cell: N-bit register with async reset, load enable and data-in. Instantiated NUM_REGS+1 times; the extra instance is INC.

Test Plan:
- Reset, then manual mode: ld_vec=0001 with addr_in=0x1234, then sel_vec=0001 → addr_out=0x1234, addr_oe=1, contention=0.
- Basic sequence: reg0=0x00FF, start with src=dst=0, DWELL=2 at edge 0:
  - addr_out=0x00FF in cycles 1–2;
  - addr_oe=0 in cycle 3;
  - addr_out=0x0100 in cycles 4–5;
  - done in cycle 6; reg0=0x0100, carry=0.
- Wrap: reg1=0xFFFF, src=1, dst=2 → reg2=0x0000, carry=1, reg1 unchanged.
- Ignored inputs while busy: start and ld_vec=1111 asserted mid-sequence → no register change, single done pulse. Also sel_vec=0011 in IDLE → contention=1, addr_out=reg0|reg1.
- Reset in DST cycle 4 → immediate IDLE, addr_oe=0, reg[dst]=0, no done pulse.
- With ADDR_INC_DECREMENT_EN defined: dec=1, reg0=0x0000, STEP=1 → reg[dst]=0xFFFF, carry=1.

Source files
------------

// File: rtl/addr_inc_pkg.sv
// Shared types and arithmetic for the address incrementer sequencer.
// Optional feature macro: ADDR_INC_DECREMENT_EN (see addr_inc_sequencer).
package addr_inc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRC,
      ST_GAP,
      ST_DST,
      ST_DONE
   } seq_state_t;

   // The INC latch sits one bit above the last address register on the LED rows.
   localparam int unsigned NUM_REGS_DEF = 4;
   localparam int unsigned INC_LED_POS  = NUM_REGS_DEF;
   localparam int unsigned MAX_W        = 64;

   // Widest supported operands; callers slice bit N as the carry/borrow.
   function automatic logic [MAX_W:0] addSub(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic             sub);
      if (sub) begin
         return {1'b0, a} - {1'b0, b};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/addr_reg_cell.sv
// One N-bit address-class register with asynchronous reset and load enable.
module addr_reg_cell #(
   parameter int unsigned N = 16
)(
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/addr_inc_sequencer.sv
// Bank of address registers plus INC latch running the relay increment sequence.
// Define ADDR_INC_DECREMENT_EN to add the 'dec' input and decrement sequences.
module addr_inc_sequencer
   import addr_inc_pkg::*;
#(
   parameter int unsigned N        = 16,
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned STEP     = 1,
   parameter int unsigned DWELL    = 2,
   localparam int unsigned IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [IW-1:0]       src_idx,
   input  logic [IW-1:0]       dst_idx,
   input  logic [NUM_REGS-1:0] ld_vec,
   input  logic [NUM_REGS-1:0] sel_vec,
   input  logic [N-1:0]        addr_in,
`ifdef ADDR_INC_DECREMENT_EN
   input  logic                dec,
`endif
   output logic [N-1:0]        addr_out,
   output logic                addr_oe,
   output logic [N-1:0]        inc_value,
   output logic                carry,
   output logic                busy,
   output logic                done,
   output logic                contention,
   output logic [NUM_REGS:0]   led_ld,
   output logic [NUM_REGS:0]   led_sel
);

   localparam int unsigned CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int unsigned INC_LED    = (NUM_REGS == NUM_REGS_DEF) ? INC_LED_POS : NUM_REGS;
   localparam logic [N-1:0]  STEP_N     = N'(STEP);
   localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL - 1);

   seq_state_t          r_state;
   seq_state_t          w_nextState;
   logic [IW-1:0]       r_srcIdx;
   logic [IW-1:0]       r_dstIdx;
   logic [CW-1:0]       r_dwell;
   logic                r_carry;
   logic [N-1:0]        w_regs [NUM_REGS];
   logic [N-1:0]        w_inc;
   logic [N-1:0]        w_regD;
   logic [N-1:0]        w_srcVal;
   logic [NUM_REGS-1:0] w_regLoad;
   logic [NUM_REGS-1:0] w_srcHit;
   logic [NUM_REGS-1:0] w_dstHit;
   logic                w_incLoad;
   logic                w_lastDwell;
   logic                w_sub;
   logic [N:0]          w_sum;

   // Sequence control: state, captured indices, dwell counter and carry latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_srcIdx <= '0;
         r_dstIdx <= '0;
         r_dwell  <= '0;
         r_carry  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_IDLE && start) begin
            r_srcIdx <= src_idx;
            r_dstIdx <= dst_idx;
            r_dwell  <= '0;
         end else if (r_state == ST_SRC || r_state == ST_DST) begin
            r_dwell <= w_lastDwell ? '0 : r_dwell + 1'b1;
         end
         if (r_state == ST_SRC && w_lastDwell) begin
            r_carry <= w_sum[N];
         end
      end
   end

`ifdef ADDR_INC_DECREMENT_EN
   logic r_dec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dec <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_dec <= dec;
      end
   end

   assign w_sub = r_dec;
`else
   assign w_sub = 1'b0;
`endif

   // Index decode; an index beyond the bank matches nothing, so it reads 0 and writes nowhere.
   always_comb begin
      w_srcVal = '0;
      w_srcHit = '0;
      w_dstHit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_srcIdx == IW'(i)) begin
            w_srcHit[i] = 1'b1;
            w_srcVal    = w_regs[i];
         end
         if (r_dstIdx == IW'(i)) begin
            w_dstHit[i] = 1'b1;
         end
      end
   end

   assign w_sum       = (N+1)'(addSub(MAX_W'(w_srcVal), MAX_W'(STEP_N), w_sub));
   assign w_lastDwell = (r_dwell == LAST_DWELL);
   assign w_regD      = (r_state == ST_DST) ? w_inc : addr_in;

   // Next state and bus/panel outputs; manual strobes only act in IDLE without start.
   always_comb begin
      w_nextState = r_state;
      addr_out    = '0;
      addr_oe     = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      contention  = 1'b0;
      led_ld      = '0;
      led_sel     = '0;
      w_regLoad   = '0;
      w_incLoad   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_nextState = ST_SRC;
            end else begin
               w_regLoad = ld_vec;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (sel_vec[i]) begin
                     addr_out = addr_out | w_regs[i];
                  end
               end
               addr_oe    = |sel_vec;
               contention = ($countones(sel_vec) > 1);
               led_ld     = {1'b0, ld_vec};
               led_sel    = {1'b0, sel_vec};
            end
         end
         ST_SRC: begin
            addr_oe          = 1'b1;
            addr_out         = w_srcVal;
            led_sel          = {1'b0, w_srcHit};
            led_ld[INC_LED]  = 1'b1;
            w_incLoad        = w_lastDwell;
            if (w_lastDwell) begin
               w_nextState = ST_GAP;
            end
         end
         ST_GAP: begin
            w_nextState = ST_DST;
         end
         ST_DST: begin
            addr_oe          = 1'b1;
            addr_out         = w_inc;
            led_sel[INC_LED] = 1'b1;
            led_ld           = {1'b0, w_dstHit};
            if (w_lastDwell) begin
               w_regLoad   = w_dstHit;
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : gRegs
      addr_reg_cell #(.N(N)) uCell (
         .i_clk   (clk),
         .i_reset (reset),
         .i_load  (w_regLoad[g]),
         .i_d     (w_regD),
         .o_q     (w_regs[g])
      );
   end

   addr_reg_cell #(.N(N)) uInc (
      .i_clk   (clk),
      .i_reset (reset),
      .i_load  (w_incLoad),
      .i_d     (w_sum[N-1:0]),
      .o_q     (w_inc)
   );

   assign inc_value = w_inc;
   assign carry     = r_carry;

endmodule

// File: tb/tb_addr_inc_sequencer.sv
// Directed self-checking bench for addr_inc_sequencer (N=16, NUM_REGS=4, STEP=1, DWELL=2).
// Covers the decrement path when ADDR_INC_DECREMENT_EN is defined.
module tb_addr_inc_sequencer;

   localparam int DWELL = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  src_idx;
   logic [1:0]  dst_idx;
   logic [3:0]  ld_vec;
   logic [3:0]  sel_vec;
   logic [15:0] addr_in;
   logic [15:0] addr_out;
   logic        addr_oe;
   logic [15:0] inc_value;
   logic        carry;
   logic        busy;
   logic        done;
   logic        contention;
   logic [4:0]  led_ld;
   logic [4:0]  led_sel;
`ifdef ADDR_INC_DECREMENT_EN
   logic        dec;
`endif

   int vectorCount = 0;
   int missCount   = 0;

   always #5 clk = ~clk;

   addr_inc_sequencer #(
      .N        (16),
      .NUM_REGS (4),
      .STEP     (1),
      .DWELL    (DWELL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_idx    (src_idx),
      .dst_idx    (dst_idx),
      .ld_vec     (ld_vec),
      .sel_vec    (sel_vec),
      .addr_in    (addr_in),
`ifdef ADDR_INC_DECREMENT_EN
      .dec        (dec),
`endif
      .addr_out   (addr_out),
      .addr_oe    (addr_oe),
      .inc_value  (inc_value),
      .carry      (carry),
      .busy       (busy),
      .done       (done),
      .contention (contention),
      .led_ld     (led_ld),
      .led_sel    (led_sel)
   );

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge; they are sampled by the next rising edge.
   task automatic applyStimulus(input logic [3:0] ld, input logic [3:0] sel, input logic [15:0] a,
                                input logic st, input logic [1:0] s, input logic [1:0] d);
      @(negedge clk);
      ld_vec  = ld;
      sel_vec = sel;
      addr_in = a;
      start   = st;
      src_idx = s;
      dst_idx = d;
      #1;
   endtask

   task automatic readReg(input logic [1:0] idx, input logic [15:0] exp);
      logic [3:0] oneHot;
      oneHot = 4'b0001 << idx;
      applyStimulus(4'b0000, oneHot, 16'h0000, 1'b0, 2'b00, 2'b00);
      checkOutput($sformatf("reg%0d", idx), addr_out, exp);
   endtask

   // Start a sequence and check every cycle up to the return to IDLE.
   task automatic runSeq(input logic [1:0] s, input logic [1:0] d, input logic [15:0] srcVal,
                         input logic [15:0] expInc, input logic inject);
      int          doneCnt;
      logic [15:0] expOut;
      logic        expOe;
      logic [4:0]  srcLed;
      logic [4:0]  dstLed;
      doneCnt = 0;
      srcLed  = 5'b00001 << s;
      dstLed  = 5'b00001 << d;
      applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b1, s, d);
      for (int c = 1; c <= 2*DWELL+3; c++) begin
         if (inject && c <= 2*DWELL+1) begin
            applyStimulus(4'b1111, 4'b0011, 16'hAAAA, 1'b1, 2'b11, 2'b00);
         end else begin
            applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0, 2'b00, 2'b00);
         end
         expOut = 16'h0000;
         expOe  = 1'b0;
         if (c <= DWELL) begin
            expOut = srcVal;
            expOe  = 1'b1;
         end else if (c >= DWELL+2 && c <= 2*DWELL+1) begin
            expOut = expInc;
            expOe  = 1'b1;
         end
         checkOutput($sformatf("seqOut c%0d", c), addr_out, expOut);
         checkOutput($sformatf("seqOe c%0d", c), addr_oe, expOe);
         checkOutput($sformatf("seqBusy c%0d", c), busy, (c <= 2*DWELL+2) ? 1 : 0);
         checkOutput($sformatf("seqDone c%0d", c), done, (c == 2*DWELL+2) ? 1 : 0);
         if (c <= 2*DWELL+2) begin
            checkOutput($sformatf("seqContention c%0d", c), contention, 0);
         end
         if (c == 1) begin
            checkOutput("srcLedSel", led_sel, srcLed);
            checkOutput("srcLedLd", led_ld, 5'b10000);
         end
         if (c == DWELL+2) begin
            checkOutput("dstLedSel", led_sel, 5'b10000);
            checkOutput("dstLedLd", led_ld, dstLed);
            checkOutput("incValue", inc_value, expInc);
         end
         if (done) begin
            doneCnt++;
         end
      end
      checkOutput("donePulses", doneCnt, 1);
   endtask

   initial begin
      int doneCnt;
      reset   = 1'b1;
      start   = 1'b0;
      src_idx = 2'b00;
      dst_idx = 2'b00;
      ld_vec  = 4'b0000;
      sel_vec = 4'b0000;
      addr_in = 16'h0000;
`ifdef ADDR_INC_DECREMENT_EN
      dec     = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstAddrOut", addr_out, 0);
      checkOutput("rstAddrOe", addr_oe, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstContention", contention, 0);
      checkOutput("rstInc", inc_value, 0);
      checkOutput("rstCarry", carry, 0);
      checkOutput("rstLedLd", led_ld, 0);
      checkOutput("rstLedSel", led_sel, 0);
      reset = 1'b0;

      // Manual load/select, then contention with two selects.
      applyStimulus(4'b0001, 4'b0000, 16'h1234, 1'b0, 2'b00, 2'b00);
      applyStimulus(4'b0010, 4'b0001, 16'h00F0, 1'b0, 2'b00, 2'b00);
      checkOutput("manOut", addr_out, 16'h1234);
      checkOutput("manOe", addr_oe, 1);
      checkOutput("manContention", contention, 0);
      applyStimulus(4'b0000, 4'b0011, 16'h0000, 1'b0, 2'b00, 2'b00);
      checkOutput("contOut", addr_out, 16'h12F4);
      checkOutput("contOe", addr_oe, 1);
      checkOutput("contFlag", contention, 1);
      applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0, 2'b00, 2'b00);
      checkOutput("idleOe", addr_oe, 0);
      checkOutput("idleContention", contention, 0);

      // Basic increment in place.
      applyStimulus(4'b0001, 4'b0000, 16'h00FF, 1'b0, 2'b00, 2'b00);
      runSeq(2'd0, 2'd0, 16'h00FF, 16'h0100, 1'b0);
      checkOutput("basicCarry", carry, 0);
      readReg(2'd0, 16'h0100);

      // Wrap-around into a different destination.
      applyStimulus(4'b0010, 4'b0000, 16'hFFFF, 1'b0, 2'b00, 2'b00);
      applyStimulus(4'b0100, 4'b0000, 16'h5555, 1'b0, 2'b00, 2'b00);
      runSeq(2'd1, 2'd2, 16'hFFFF, 16'h0000, 1'b0);
      checkOutput("wrapCarry", carry, 1);
      readReg(2'd2, 16'h0000);
      readReg(2'd1, 16'hFFFF);

      // Inputs hammered while busy must not disturb anything.
      applyStimulus(4'b1000, 4'b0000, 16'h7777, 1'b0, 2'b00, 2'b00);
      runSeq(2'd2, 2'd3, 16'h0000, 16'h0001, 1'b1);
      checkOutput("injCarry", carry, 0);
      readReg(2'd3, 16'h0001);
      readReg(2'd0, 16'h0100);
      readReg(2'd1, 16'hFFFF);
      readReg(2'd2, 16'h0000);

      // Reset during the first DST cycle.
      applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b1, 2'd0, 2'd1);
      for (int c = 1; c <= DWELL+2; c++) begin
         applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0, 2'b00, 2'b00);
      end
      checkOutput("preRstOut", addr_out, 16'h0101);
      checkOutput("preRstOe", addr_oe, 1);
      reset = 1'b1;
      #1;
      checkOutput("midRstOe", addr_oe, 0);
      checkOutput("midRstOut", addr_out, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstInc", inc_value, 0);
      @(negedge clk);
      reset = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0, 2'b00, 2'b00);
         if (done || busy) begin
            doneCnt++;
         end
      end
      checkOutput("postRstActivity", doneCnt, 0);
      readReg(2'd1, 16'h0000);
      readReg(2'd0, 16'h0000);

`ifdef ADDR_INC_DECREMENT_EN
      // Decrement through zero borrows.
      dec = 1'b1;
      runSeq(2'd0, 2'd1, 16'h0000, 16'hFFFF, 1'b0);
      dec = 1'b0;
      checkOutput("decCarry", carry, 1);
      readReg(2'd1, 16'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
